serial_bit_feeder: RTL and testbench

Parallel-to-serial feeder that sits directly upstream of the serial sequence detector. It accepts WIDTH-bit words through a valid/ready handshake and drives them out as one bit per clock on a single-bit stream that connects straight to the detector's `in`. A one-word holding register lets consecutive words stream with no idle gap. When no data is pending, the stream holds a fixed idle level.

---
 rtl/serial_bit_feeder.sv | 113 +++++++++++
 tb/tb_serial_bit_feeder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: WIDTH-bit words in over valid/ready, one bit per clock out.
// A one-word holding register lets a new word follow the previous one with no gap cycle.
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             word_done
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] hold_reg, hold_next;
  logic             hold_full_reg, hold_full_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [BW-1:0]    bcnt_reg, bcnt_next;
  logic             out_reg, out_next;
  logic             out_valid_reg, out_valid_next;
  logic             frame_start_reg, frame_start_next;
  logic             word_done_reg, word_done_next;
  logic             accept;
  logic             head_next;

  assign in_ready = !hold_full_reg && !rst;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      hold_reg        <= '0;
      hold_full_reg   <= 1'b0;
      shreg_reg       <= '0;
      bcnt_reg        <= '0;
      out_reg         <= IDLE_BIT;
      out_valid_reg   <= 1'b0;
      frame_start_reg <= 1'b0;
      word_done_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      hold_reg        <= hold_next;
      hold_full_reg   <= hold_full_next;
      shreg_reg       <= shreg_next;
      bcnt_reg        <= bcnt_next;
      out_reg         <= out_next;
      out_valid_reg   <= out_valid_next;
      frame_start_reg <= frame_start_next;
      word_done_reg   <= word_done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    shreg_next     = shreg_reg;
    bcnt_next      = bcnt_reg;

    case (state_reg)
      IDLE: begin
        if (hold_full_reg) begin
          shreg_next     = hold_reg;
          hold_full_next = 1'b0;
          bcnt_next      = '0;
          state_next     = SHIFT;
        end
      end
      SHIFT: begin
        if (bcnt_reg != LAST) begin
          shreg_next = MSB_FIRST ? (shreg_reg << 1) : (shreg_reg >> 1);
          bcnt_next  = bcnt_reg + 1'b1;
        end else if (hold_full_reg) begin
          shreg_next     = hold_reg;
          hold_full_next = 1'b0;
          bcnt_next      = '0;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // accept only happens with hold empty, so it never races a reload's clear
    if (accept) begin
      hold_next      = in_data;
      hold_full_next = 1'b1;
    end

    // outputs are precomputed for the next cycle so each one comes straight from a flop
    head_next        = MSB_FIRST ? shreg_next[WIDTH-1] : shreg_next[0];
    out_next         = (state_next == SHIFT) ? head_next : IDLE_BIT;
    out_valid_next   = (state_next == SHIFT);
    frame_start_next = (state_next == SHIFT) && (bcnt_next == '0);
    word_done_next   = (state_next == SHIFT) && (bcnt_next == LAST);
  end

  assign out         = out_reg;
  assign out_valid   = out_valid_reg;
  assign frame_start = frame_start_reg;
  assign word_done   = word_done_reg;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: an MSB-first and an LSB-first instance
// sharing clock and reset, checked cycle by cycle against hand-computed bit sequences.
module tb_serial_bit_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ready, m_out, m_ovalid, m_fs, m_wd;
  logic [7:0] l_data = 8'h00;
  logic       l_valid = 1'b0;
  logic       l_ready, l_out, l_ovalid, l_fs, l_wd;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
    .clk(clk), .rst(rst), .in_data(m_data), .in_valid(m_valid), .in_ready(m_ready),
    .out(m_out), .out_valid(m_ovalid), .frame_start(m_fs), .word_done(m_wd)
  );

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
    .clk(clk), .rst(rst), .in_data(l_data), .in_valid(l_valid), .in_ready(l_ready),
    .out(l_out), .out_valid(l_ovalid), .frame_start(l_fs), .word_done(l_wd)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // inputs change and outputs are sampled 1 time unit after each rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered during the first-bit cycle of word w on the MSB-first instance.
  task automatic check_msb_word(input string tag, input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      $display("%s bit %0d: out=%b valid=%b fs=%b wd=%b", tag, i, m_out, m_ovalid, m_fs, m_wd);
      chk({tag, " out"}, m_out, w[7-i]);
      chk({tag, " out_valid"}, m_ovalid, 1'b1);
      chk({tag, " frame_start"}, m_fs, i == 0);
      chk({tag, " word_done"}, m_wd, i == 7);
      tick();
    end
  endtask

  task automatic accept_m(input logic [7:0] w);
    m_data  = w;
    m_valid = 1'b1;
    chk("accept in_ready", m_ready, 1'b1);
    tick();
    m_valid = 1'b0;
    m_data  = 8'h00;
  endtask

  initial begin
    // asynchronous reset with no clock edge in between
    #2 rst = 1'b1;
    #1;
    chk("rst out", m_out, 1'b0);
    chk("rst out_valid", m_ovalid, 1'b0);
    chk("rst in_ready", m_ready, 1'b0);
    chk("rst lsb in_ready", l_ready, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("post-rst in_ready", m_ready, 1'b1);
    chk("post-rst out_valid", m_ovalid, 1'b0);

    // single word 0xCE
    accept_m(8'hCE);
    chk("ce wait in_ready", m_ready, 1'b0);
    chk("ce wait out_valid", m_ovalid, 1'b0);
    tick();
    check_msb_word("ce", 8'hCE);
    chk("ce idle out_valid", m_ovalid, 1'b0);
    chk("ce idle out", m_out, 1'b0);
    tick();

    // back-to-back: 0x3C accepted during bit 3 of 0xA5
    accept_m(8'hA5);
    tick();
    for (int i = 0; i < 8; i++) begin
      $display("a5 bit %0d: out=%b valid=%b ready=%b", i, m_out, m_ovalid, m_ready);
      chk("a5 out", m_out, (8'hA5 >> (7 - i)) & 1'b1);
      chk("a5 out_valid", m_ovalid, 1'b1);
      if (i == 3) begin
        chk("a5 ready before 2nd", m_ready, 1'b1);
        m_data  = 8'h3C;
        m_valid = 1'b1;
      end
      if (i >= 4) chk("a5 ready held low", m_ready, 1'b0);
      tick();
      m_valid = 1'b0;
    end
    chk("3c ready after reload", m_ready, 1'b1);
    check_msb_word("3c", 8'h3C);
    chk("3c idle out_valid", m_ovalid, 1'b0);
    tick();

    // late second word: 0x5A accepted on the last-bit edge of 0x96
    accept_m(8'h96);
    tick();
    for (int i = 0; i < 8; i++) begin
      $display("96 bit %0d: out=%b valid=%b", i, m_out, m_ovalid);
      chk("96 out", m_out, (8'h96 >> (7 - i)) & 1'b1);
      chk("96 out_valid", m_ovalid, 1'b1);
      if (i == 7) begin
        chk("96 ready at last bit", m_ready, 1'b1);
        m_data  = 8'h5A;
        m_valid = 1'b1;
      end
      tick();
      m_valid = 1'b0;
    end
    chk("gap out_valid", m_ovalid, 1'b0);
    chk("gap out", m_out, 1'b0);
    tick();
    check_msb_word("5a", 8'h5A);
    chk("5a idle out_valid", m_ovalid, 1'b0);
    tick();

    // LSB-first 0x01
    l_data  = 8'h01;
    l_valid = 1'b1;
    chk("lsb accept ready", l_ready, 1'b1);
    tick();
    l_valid = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      $display("lsb bit %0d: out=%b valid=%b fs=%b wd=%b", i, l_out, l_ovalid, l_fs, l_wd);
      chk("lsb out", l_out, i == 0);
      chk("lsb out_valid", l_ovalid, 1'b1);
      chk("lsb frame_start", l_fs, i == 0);
      chk("lsb word_done", l_wd, i == 7);
      tick();
    end
    chk("lsb idle out_valid", l_ovalid, 1'b0);
    tick();

    // reset mid-word: 0xFF shifting, 0x81 pending in hold
    accept_m(8'hFF);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        m_data  = 8'h81;
        m_valid = 1'b1;
      end
      tick();
      m_valid = 1'b0;
    end
    chk("pre-rst out", m_out, 1'b1);
    chk("pre-rst in_ready", m_ready, 1'b0);
    #1 rst = 1'b1;
    #1;
    $display("mid-word reset: out=%b valid=%b ready=%b", m_out, m_ovalid, m_ready);
    chk("midrst out", m_out, 1'b0);
    chk("midrst out_valid", m_ovalid, 1'b0);
    chk("midrst frame_start", m_fs, 1'b0);
    chk("midrst word_done", m_wd, 1'b0);
    chk("midrst in_ready", m_ready, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("midrst release in_ready", m_ready, 1'b1);
    for (int i = 0; i < 12; i++) begin
      chk("no resume out_valid", m_ovalid, 1'b0);
      chk("no resume out", m_out, 1'b0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
